instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the combinational instruction ROM. Owns the PC and drives the ROM address.
//  Each cycle it captures {pc, instruction} into a small fetch queue.
//  Hands queued instructions to decode over a valid/ready handshake.
//  Handles branch redirects (flush + new PC) and halts on illegal fetch addresses.
// PARAMETERS
//  MEM_SIZE   1024   ROM size in bytes; power of two, >4
//  DEPTH      2      fetch-queue entries; power of two, >=2
//  RESET_PC   64'd0  PC value after reset; word-aligned
// PORTS
//  clk            in   1   clock; all state on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  imem_addr      out  64  ROM byte address; always equals the PC register
//  imem_instr     in   32  ROM read data; same-cycle combinational return for imem_addr
//  if_valid       out  1   queue head is valid
//  if_ready       in   1   decode accepts the head this cycle
//  if_instr       out  32  head instruction; 32'd0 when !if_valid
//  if_pc          out  64  head PC; 64'd0 when !if_valid
//  redirect_valid in   1   branch taken; flush the queue and refetch from redirect_pc
//  redirect_pc    in   64  redirect target
//  fault          out  1   fetch halted on a misaligned or out-of-range PC
// BEHAVIOUR
//  Reset (reset_n=0, async) sets:
//   - pc=RESET_PC, queue empty, state=RUN
//   - if_valid=0, if_instr=0, if_pc=0, fault=0, imem_addr=RESET_PC
//  The controller has two states, RUN and FAULT; fault=(state==FAULT), registered.
//  legal(pc) = (pc[1:0]==0) && (pc+3 < MEM_SIZE). Compute pc+3 in 64 bits; pc near 2^64 wraps and counts as illegal.
//  pop  = if_valid && if_ready.
//  push = state==RUN && legal(pc) && !redirect_valid && (count<DEPTH || pop).
//  On push:
//   - enqueue {pc, imem_instr} at tail
//   - pc <= pc+4
//   - the entry is visible on if_* the next cycle
//  Latency: 1 cycle from address to the head; 1 instruction/cycle sustained while if_ready=1.
//  Full with no pop: no push, pc holds, imem_addr stable (stall).
//  Full with a pop in the same cycle: push and pop together; count is unchanged.
//  Empty with a push: no same-cycle bypass; if_valid rises the next cycle.
//  RUN && !legal(pc) && !redirect_valid: go to FAULT next cycle. No push; pc holds. Queued entries keep draining.
//  FAULT: no pushes. Remain in FAULT until a redirect to a legal target.
//  redirect_valid (priority over push and pop):
//   - next cycle: queue empty, if_valid=0, pc=redirect_pc, no push this cycle
//   - a pop in the same cycle is discarded; if_ready is ignored
//   - next state = legal(redirect_pc) ? RUN : FAULT
//  Reset asserted mid-operation drops all entries immediately (async); pc returns to RESET_PC.
//  Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  Assertions:
//   - count<=DEPTH
//   - no push when full without a pop
//   - if_instr and if_pc stable while if_valid && !if_ready
// STRUCTURE
//  Package fetch_pkg holds:
//   - typedef fetch_entry_t {logic [63:0] pc; logic [31:0] instr;}
//   - enum fetch_state_e {RUN, FAULT}
//   - function legal_fetch_addr(pc, mem_size)
//  One sub-module: fetch_queue. A DEPTH-entry FIFO of fetch_entry_t with push/pop/flush, full/empty, count.
//  Top level holds the PC register, the FSM and the push/pop/redirect priority logic.
// TESTING
//  Bench drives imem_instr from an instructmem instance with a known image: word i = 32'hA000_0000+i.
//  1 Reset, then if_ready=1 for 6 cycles.
//    -> if_valid rises on cycle 1; if_pc = 0,4,8,...; if_instr = A0000000,A0000001,... one per cycle.
//  2 if_ready=0 for 5 cycles after reset.
//    -> queue fills to DEPTH=2 (pc 0,4); imem_addr holds 8.
//    -> raising if_ready then delivers 0,4,8 back-to-back with no bubble.
//  3 redirect_valid with redirect_pc=0x40 while 2 entries are queued and if_ready=1.
//    -> next cycle if_valid=0, imem_addr=0x40.
//    -> following cycle if_pc=0x40, if_instr=A0000010; flushed entries are never seen.
//  4 redirect_pc=0x3FC, run with if_ready=1.
//    -> delivers pc 0x3FC; at pc=0x400, fault=1 one cycle later; no further if_valid.
//    -> redirect to 0x10 clears fault and fetching resumes.
//  5 redirect_pc=0x6 (misaligned).
//    -> fault=1 the next cycle with queue empty; imem_addr=0x6 held.
//  6 Drop reset_n between clock edges with 2 entries queued.
//    -> if_valid=0, fault=0, imem_addr=RESET_PC immediately, before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and the address-legality helper for the instruction fetch path.
package fetch_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    // pc+3 is taken modulo 2^64, so an address wrapping past the top reads as out of range
    function automatic logic legal_fetch_addr(input logic [63:0] pc, input logic [63:0] mem_size);
        logic [63:0] last_byte;
        last_byte = pc + 64'd3;
        return (pc[1:0] == 2'b00) && (last_byte < mem_size) && (last_byte >= pc);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // When full, a simultaneous pop reads this slot before the edge that overwrites it
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fills the fetch queue from the ROM, handles redirects and faults.
//  state | meaning
//  RUN   | fetching sequentially from pc while the queue has room
//  FAULT | halted on an illegal pc; waits for a redirect to a legal target
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          MEM_SIZE = 1024,
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_e state, state_nxt;
    logic [63:0]  pc, pc_nxt;
    fetch_entry_t head, new_entry;
    logic         empty, full, pop, q_pop, push, pc_legal;
    logic [AW:0]  count;
    logic         hold_q;
    fetch_entry_t held_q;

    assign pc_legal  = legal_fetch_addr(pc, 64'(MEM_SIZE));
    assign if_valid  = !empty;
    assign pop       = if_valid && if_ready;
    assign q_pop     = pop && !redirect_valid;
    assign push      = (state == RUN) && pc_legal && !redirect_valid && (!full || pop);
    assign new_entry = '{pc: pc, instr: imem_instr};
    assign imem_addr = pc;
    assign fault     = (state == FAULT);
    assign if_instr  = if_valid ? head.instr : 32'd0;
    assign if_pc     = if_valid ? head.pc : 64'd0;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect_valid) begin
            pc_nxt    = redirect_pc;
            state_nxt = legal_fetch_addr(redirect_pc, 64'(MEM_SIZE)) ? RUN : FAULT;
        end else begin
            if (push)
                pc_nxt = pc + 64'd4;
            if (state == RUN && !pc_legal)
                state_nxt = FAULT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (q_pop),
        .flush   (redirect_valid),
        .wdata   (new_entry),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // A stalled head must not change under decode until it is taken or flushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= 1'b0;
            held_q <= '0;
        end else begin
            hold_q <= if_valid && !if_ready && !redirect_valid;
            held_q <= '{pc: if_pc, instr: if_instr};
            assert (count <= (AW+1)'(DEPTH));
            assert (!(push && full && !pop));
            assert (!hold_q || (if_pc == held_q.pc && if_instr == held_q.instr));
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: fill/stall, redirect, fault entry/exit and async reset.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM image: word i holds A000_0000 + i
    assign imem_instr = 32'hA000_0000 + imem_addr[33:2];

    instr_fetch_ctrl #(.MEM_SIZE(1024), .DEPTH(2), .RESET_PC(64'd0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: streaming with if_ready held high
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        do_reset();
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_pc", if_pc, 64'd0);
        check("rst_instr", 64'(if_instr), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("s1_valid", 64'(if_valid), 64'd1);
            check("s1_pc", if_pc, 64'(4 * i));
            check("s1_instr", 64'(if_instr), 64'(32'hA000_0000 + 32'(i)));
        end

        // 2: stall until full, then drain back-to-back
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++)
            tick();
        check("s2_valid", 64'(if_valid), 64'd1);
        check("s2_head", if_pc, 64'd0);
        check("s2_addr_hold", imem_addr, 64'd8);
        if_ready = 1'b1;
        tick();
        check("s2_pc4", if_pc, 64'd4);
        check("s2_instr4", 64'(if_instr), 64'hA000_0001);
        tick();
        check("s2_pc8", if_pc, 64'd8);
        check("s2_instr8", 64'(if_instr), 64'hA000_0002);

        // 3: redirect to 0x40 with two entries queued
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        check("s3_flush_valid", 64'(if_valid), 64'd0);
        check("s3_addr", imem_addr, 64'h40);
        check("s3_flush_pc", if_pc, 64'd0);
        tick();
        check("s3_pc", if_pc, 64'h40);
        check("s3_instr", 64'(if_instr), 64'hA000_0010);
        check("s3_fault", 64'(fault), 64'd0);

        // 4: run off the end of the ROM, then recover
        redirect_valid = 1'b1;
        redirect_pc = 64'h3FC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("s4_pc", if_pc, 64'h3FC);
        check("s4_instr", 64'(if_instr), 64'hA000_00FF);
        check("s4_fault_pre", 64'(fault), 64'd0);
        tick();
        check("s4_fault", 64'(fault), 64'd1);
        check("s4_valid", 64'(if_valid), 64'd0);
        check("s4_addr", imem_addr, 64'h400);
        tick();
        check("s4_valid_held", 64'(if_valid), 64'd0);
        check("s4_fault_held", 64'(fault), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h10;
        tick();
        redirect_valid = 1'b0;
        check("s4_fault_clr", 64'(fault), 64'd0);
        check("s4_addr_10", imem_addr, 64'h10);
        tick();
        check("s4_resume_pc", if_pc, 64'h10);
        check("s4_resume_instr", 64'(if_instr), 64'hA000_0004);

        // 5: misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc = 64'h6;
        tick();
        redirect_valid = 1'b0;
        check("s5_fault", 64'(fault), 64'd1);
        check("s5_valid", 64'(if_valid), 64'd0);
        check("s5_addr", imem_addr, 64'h6);
        tick();
        check("s5_addr_held", imem_addr, 64'h6);
        check("s5_valid_held", 64'(if_valid), 64'd0);

        // 6: asynchronous reset with two entries queued
        redirect_valid = 1'b1;
        redirect_pc = 64'h20;
        if_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("s6_pre_valid", 64'(if_valid), 64'd1);
        check("s6_pre_addr", imem_addr, 64'h28);
        #3;
        reset_n = 1'b0;
        #1;
        check("s6_valid", 64'(if_valid), 64'd0);
        check("s6_fault", 64'(fault), 64'd0);
        check("s6_addr", imem_addr, 64'd0);
        check("s6_pc", if_pc, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
